if_fetch_unit: RTL

Instruction-fetch stage that produces the inst_IF / pc_IF / pc4_IF triple consumed by the IF/ID pipeline register. It owns the PC and issues one-outstanding requests on a variable-latency instruction-memory request/grant/response interface. It holds one fetched instruction in an output buffer, honours the downstream stall, and services branch/jump redirects from EX by discarding stale responses.

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/if_fetch_unit_if.sv | 23 ++
 rtl/if_fetch_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
//   fetch_state_e : fetch FSM encoding
//   DEF_RESET_PC  : default first fetch address after reset
//   DEF_NOP_INST  : bubble instruction, identical to the IF/ID flush value
//   pc_plus4()    : sequential PC step, wraps modulo 2^32
package pipeline_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/grant/response bus.
//   imem_req    : fetch request (master -> slave)
//   imem_addr   : fetch address (master -> slave)
//   imem_gnt    : request accepted this cycle (slave -> master)
//   imem_rvalid : response valid, at least one cycle after grant
//   imem_rdata  : fetched instruction word
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Owns the PC, issues one outstanding request at a
// time on the imem bus, holds one fetched instruction for the IF/ID register,
// honours the downstream stall and discards stale responses after a redirect.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   stall_IF           : downstream hold, buffered instruction not consumed
//   redirect_valid/pc  : taken branch/jump from EX and its target
//   imem               : instruction-memory bus (master side)
//   inst_IF            : buffered instruction, NOP_INST when invalid
//   pc_IF, pc4_IF      : PC of the buffered instruction and PC+4
//   inst_valid_IF      : buffer holds a valid instruction
//   fetch_stall        : ~inst_valid_IF, used by the hazard unit to bubble IF/ID
module if_fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = pipeline_pkg::DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = pipeline_pkg::DEF_NOP_INST
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall_IF,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  if_fetch_unit_if.master         imem,
  output logic [31:0]             inst_IF,
  output logic [31:0]             pc_IF,
  output logic [31:0]             pc4_IF,
  output logic                    inst_valid_IF,
  output logic                    fetch_stall
);

  fetch_state_e r_state, w_next_state;

  logic [31:0] r_pc;
  logic [31:0] r_inst_buf;
  logic [31:0] r_pc_IF;
  logic [31:0] r_pc4_IF;
  logic        r_inst_valid;

  logic w_req;
  logic w_grant;
  logic w_consume;
  logic w_load;

  assign w_consume = r_inst_valid & ~stall_IF;

  // Buffer load only from a live response; a redirect in the same cycle
  // turns the response stale.
  assign w_load = (r_state == S_WAIT) & imem.imem_rvalid & ~redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    w_grant      = 1'b0;
    case (r_state)
      S_IDLE: w_next_state = S_REQ;
      S_REQ: begin
        // Request only when the buffer is free or is being consumed now, so
        // the single in-flight response always finds an empty buffer.
        w_req   = ~r_inst_valid | ~stall_IF;
        w_grant = w_req & imem.imem_gnt;
        if (w_grant) w_next_state = S_WAIT;
      end
      S_WAIT: if (imem.imem_rvalid) w_next_state = S_REQ;
      S_DROP: if (imem.imem_rvalid) w_next_state = S_REQ;
      default: w_next_state = S_IDLE;
    endcase

    if (redirect_valid) begin
      // Any request still in flight after this edge must have its response
      // swallowed in S_DROP. A redirect while already dropping keeps
      // dropping, otherwise the stale word could land in a later S_WAIT.
      if (w_grant ||
          (r_state == S_WAIT && !imem.imem_rvalid) ||
          (r_state == S_DROP && !imem.imem_rvalid))
        w_next_state = S_DROP;
      else
        w_next_state = S_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_inst_buf   <= NOP_INST;
      r_pc_IF      <= 32'h0;
      r_pc4_IF     <= 32'h0;
      r_inst_valid <= 1'b0;
    end else if (redirect_valid) begin
      r_pc         <= redirect_pc;
      r_inst_valid <= 1'b0;
    end else if (w_load) begin
      r_inst_buf   <= imem.imem_rdata;
      r_pc_IF      <= r_pc;
      r_pc4_IF     <= pc_plus4(r_pc);
      r_inst_valid <= 1'b1;
      r_pc         <= pc_plus4(r_pc);
    end else if (w_consume) begin
      r_inst_valid <= 1'b0;
    end
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;

  assign inst_IF       = r_inst_valid ? r_inst_buf : NOP_INST;
  assign pc_IF         = r_pc_IF;
  assign pc4_IF        = r_pc4_IF;
  assign inst_valid_IF = r_inst_valid;
  assign fetch_stall   = ~r_inst_valid;

endmodule
